// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the issuing pipeline and the iterative
// multiply/divide unit.
interface muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] operand_a;
    logic [XLEN-1:0] operand_b;
    logic            flush;
    logic            busy;
    logic            stall;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, funct3, operand_a, operand_b, flush,
        input  busy, stall, done, result
    );

    modport slave (
        input  start, funct3, operand_a, operand_b, flush,
        output busy, stall, done, result
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV-style M-extension unit: shift-add multiply and restoring divide,
// one bit per cycle, with single-cycle handling of divide-by-zero and overflow.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic          clock,
    input  logic          reset,
    muldiv_unit_if.slave  bus
);
    localparam int CW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CW-1:0]     r_count;
    logic [2:0]        r_funct3;
    logic [XLEN-1:0]   r_mcand;
    logic [2*XLEN-1:0] r_acc;
    logic              r_neg_main;
    logic              r_neg_rem;
    logic [XLEN-1:0]   r_result;

    // Operand decode on the live inputs, used only in the accepting cycle.
    logic            w_accept;
    logic            w_is_div;
    logic            w_signed_a;
    logic            w_signed_b;
    logic            w_sign_a;
    logic            w_sign_b;
    logic [XLEN-1:0] w_mag_a;
    logic [XLEN-1:0] w_mag_b;
    logic            w_div_zero;
    logic            w_overflow;
    logic            w_special;
    logic [XLEN-1:0] w_special_res;

    assign w_accept   = (r_state == IDLE) && bus.start && !bus.flush && !reset;
    assign w_is_div   = bus.funct3[2];
    assign w_signed_a = bus.funct3[2] ? !bus.funct3[0]
                                      : (bus.funct3[1:0] == 2'b01 || bus.funct3[1:0] == 2'b10);
    assign w_signed_b = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
    assign w_sign_a   = w_signed_a && bus.operand_a[XLEN-1];
    assign w_sign_b   = w_signed_b && bus.operand_b[XLEN-1];
    assign w_mag_a    = w_sign_a ? -bus.operand_a : bus.operand_a;
    assign w_mag_b    = w_sign_b ? -bus.operand_b : bus.operand_b;

    assign w_div_zero = w_is_div && (bus.operand_b == '0);
    assign w_overflow = w_is_div && !bus.funct3[0]
                        && (bus.operand_a == {1'b1, {(XLEN-1){1'b0}}})
                        && (bus.operand_b == '1);
    assign w_special  = w_div_zero || w_overflow;
    assign w_special_res = w_div_zero ? (bus.funct3[1] ? bus.operand_a : '1)
                                      : (bus.funct3[1] ? '0 : bus.operand_a);

    // Multiply step: conditionally add multiplicand to the high half, shift right.
    logic [XLEN:0]     w_add;
    logic [2*XLEN-1:0] w_mul_next;
    assign w_add      = r_acc[0] ? ({1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, r_mcand})
                                 :  {1'b0, r_acc[2*XLEN-1:XLEN]};
    assign w_mul_next = {w_add, r_acc[XLEN-1:1]};

    // Divide step: shift partial remainder left, trial-subtract the divisor.
    logic [XLEN:0]     w_rem_sh;
    logic [XLEN:0]     w_sub;
    logic              w_ge;
    logic [2*XLEN-1:0] w_div_next;
    assign w_rem_sh   = r_acc[2*XLEN-1:XLEN-1];
    assign w_sub      = w_rem_sh - {1'b0, r_mcand};
    assign w_ge       = (w_rem_sh >= {1'b0, r_mcand});
    assign w_div_next = {(w_ge ? w_sub[XLEN-1:0] : w_rem_sh[XLEN-1:0]), r_acc[XLEN-2:0], w_ge};

    logic [2*XLEN-1:0] w_acc_next;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_final;

    assign w_acc_next = r_funct3[2] ? w_div_next : w_mul_next;
    assign w_prod     = r_neg_main ? -w_acc_next : w_acc_next;
    assign w_quo      = r_neg_main ? -w_acc_next[XLEN-1:0] : w_acc_next[XLEN-1:0];
    assign w_rem      = r_neg_rem  ? -w_acc_next[2*XLEN-1:XLEN] : w_acc_next[2*XLEN-1:XLEN];

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        w_final = w_prod[XLEN-1:0];
        case (r_funct3)
            3'b001, 3'b010, 3'b011: w_final = w_prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         w_final = w_quo;
            3'b110, 3'b111:         w_final = w_rem;
            default:                w_final = w_prod[XLEN-1:0];
        endcase
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = w_special ? DONE : COMPUTE;
            COMPUTE: begin
                if (bus.flush)
                    w_next = IDLE;
                else if (r_count == CW'(1))
                    w_next = DONE;
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_count    <= '0;
            r_funct3   <= '0;
            r_mcand    <= '0;
            r_acc      <= '0;
            r_neg_main <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_result   <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_funct3   <= bus.funct3;
                r_count    <= CW'(XLEN);
                r_acc      <= {{XLEN{1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
                r_mcand    <= w_is_div ? w_mag_b : w_mag_a;
                r_neg_main <= w_sign_a ^ w_sign_b;
                r_neg_rem  <= w_sign_a;
                if (w_special)
                    r_result <= w_special_res;
            end else if (r_state == COMPUTE && !bus.flush) begin
                r_count <= r_count - CW'(1);
                r_acc   <= w_acc_next;
                if (r_count == CW'(1))
                    r_result <= w_final;
            end
        end
    end

    assign bus.busy   = (r_state != IDLE);
    assign bus.stall  = w_accept || (r_state == COMPUTE);
    assign bus.done   = (r_state == DONE) && !bus.flush;
    assign bus.result = r_result;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit at XLEN = 32.
module tb_muldiv_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    muldiv_unit_if #(.XLEN(32)) bus ();

    muldiv_unit #(.XLEN(32)) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one op at a negedge (cycle 0) and follow it to its done pulse.
    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                          input bit hold_start);
        int cyc;
        int stall_cnt;
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = f; bus.operand_a = a; bus.operand_b = b;
        #1;
        check({tag, "_stall_accept"}, 64'(bus.stall), 64'd1);
        stall_cnt = 1;
        cyc = 0;
        @(negedge clk);
        bus.start     = hold_start;
        bus.funct3    = ~f;
        bus.operand_a = ~a;
        bus.operand_b = b ^ 32'h5A5A_5A5A;
        cyc = 1;
        #1;
        while (!bus.done && cyc < 100) begin
            if (bus.stall) stall_cnt++;
            @(negedge clk);
            #1;
            cyc++;
        end
        bus.start = 1'b0;
        check({tag, "_latency"},  64'(cyc), 64'(exp_lat));
        check({tag, "_result"},   64'(bus.result), 64'(exp));
        check({tag, "_stall_cnt"}, 64'(stall_cnt), 64'(exp_lat));
        check({tag, "_busy_done"}, 64'(bus.busy), 64'd1);
        check({tag, "_stall_done"}, 64'(bus.stall), 64'd0);
        @(negedge clk);
        #1;
        check({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
        check({tag, "_busy_after"}, 64'(bus.busy), 64'd0);
    endtask

    initial begin
        int n_done;
        bus.start = 1'b0; bus.funct3 = 3'b000; bus.flush = 1'b0;
        bus.operand_a = '0; bus.operand_b = '0;

        #1;
        check("rst_busy",   64'(bus.busy),   64'd0);
        check("rst_stall",  64'(bus.stall),  64'd0);
        check("rst_done",   64'(bus.done),   64'd0);
        check("rst_result", 64'(bus.result), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_op("mul_7x-3",     3'b000, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 1'b0);
        run_op("mulhu_ff",     3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 1'b0);
        run_op("mulh_ff",      3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33, 1'b0);
        run_op("mulhsu_ffx2",  3'b010, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 33, 1'b0);
        run_op("mulh_min2",    3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, 1'b0);
        run_op("mulhsu_min",   3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33, 1'b0);
        run_op("div_-7/2",     3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33, 1'b1);
        run_op("rem_-7/2",     3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33, 1'b0);
        run_op("div_7/-2",     3'b100, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33, 1'b0);
        run_op("rem_7/-2",     3'b110, 32'd7,         32'hFFFF_FFFE, 32'd1,         33, 1'b0);
        run_op("divu_100/7",   3'b101, 32'd100,       32'd7,         32'd14,        33, 1'b0);
        run_op("remu_100/7",   3'b111, 32'd100,       32'd7,         32'd2,         33, 1'b0);
        run_op("divu_5/0",     3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1,  1'b0);
        run_op("rem_5/0",      3'b110, 32'd5,         32'd0,         32'd5,         1,  1'b0);
        run_op("div_5/0",      3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF, 1,  1'b0);
        run_op("div_ovf",      3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,  1'b0);
        run_op("rem_ovf",      3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1,  1'b0);
        run_op("mul_3x4",      3'b000, 32'd3,         32'd4,         32'd12,        33, 1'b0);

        // Flush a MUL in cycle 10: back to IDLE, no done, result still 12.
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = 3'b000; bus.operand_a = 32'd5; bus.operand_b = 32'd6;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        bus.flush = 1'b1;
        #1;
        check("flush_done_c10", 64'(bus.done), 64'd0);
        @(negedge clk);
        bus.flush = 1'b0;
        #1;
        check("flush_busy_c11",  64'(bus.busy),  64'd0);
        check("flush_stall_c11", 64'(bus.stall), 64'd0);
        n_done = 0;
        repeat (40) begin
            @(negedge clk);
            #1;
            if (bus.done) n_done++;
        end
        check("flush_no_done", 64'(n_done), 64'd0);
        check("flush_result",  64'(bus.result), 64'd12);

        // start together with flush in IDLE is refused.
        @(negedge clk);
        bus.start = 1'b1; bus.flush = 1'b1; bus.funct3 = 3'b101;
        bus.operand_a = 32'd9; bus.operand_b = 32'd0;
        #1;
        check("sf_stall", 64'(bus.stall), 64'd0);
        @(negedge clk);
        bus.start = 1'b0; bus.flush = 1'b0;
        #1;
        check("sf_busy",   64'(bus.busy),   64'd0);
        check("sf_done",   64'(bus.done),   64'd0);
        check("sf_result", 64'(bus.result), 64'd12);

        // Reset in cycle 15 of a DIV clears everything at once.
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = 3'b100; bus.operand_a = 32'd1000; bus.operand_b = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (13) @(negedge clk);
        #1;
        check("pre_rst_busy", 64'(bus.busy), 64'd1);
        @(negedge clk);
        bus.start = 1'b1;
        rst = 1'b1;
        #1;
        check("midrst_busy",   64'(bus.busy),   64'd0);
        check("midrst_stall",  64'(bus.stall),  64'd0);
        check("midrst_done",   64'(bus.done),   64'd0);
        check("midrst_result", 64'(bus.result), 64'd0);
        @(negedge clk);
        bus.start = 1'b0;
        rst = 1'b0;
        #1;
        check("postrst_done", 64'(bus.done), 64'd0);
        run_op("mul_3x4_rst", 3'b000, 32'd3, 32'd4, 32'd12, 33, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter: XLEN, default 32, operand/result width; legal values 8..64, even.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately when asserted.
REQ-004 start  input  1  request new operation; sampled only in IDLE.
REQ-005 funct3  input  3  operation: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 operand_a  input  XLEN  rs1 value; dividend or multiplicand.
REQ-007 operand_b  input  XLEN  rs2 value; divisor or multiplier.
REQ-008 flush  input  1  abort in-flight op (branch taken / pipeline kill).
REQ-009 busy  output  1  high while an operation is in COMPUTE or DONE.
REQ-010 stall  output  1  pipeline hold request to fetch/decode stages.
REQ-011 done  output  1  one-cycle pulse; result valid.
REQ-012 result  output  XLEN  operation result; held until the next accepted start.

Function
REQ-013 FSM states SHALL be IDLE, COMPUTE, DONE.
REQ-014 IDLE & start & !flush: capture operands and funct3, load counter = XLEN, go to COMPUTE.
REQ-015 Signed ops: operate on magnitudes; MULH: both signed; MULHSU: a signed, b unsigned; MULHU/DIVU/REMU: unsigned.
REQ-016 Multiply: shift-add, one multiplier bit per cycle, 2*XLEN-bit product; MUL returns low XLEN bits, MULH* return high XLEN bits; product negated when the operand signs differ.
REQ-017 Divide: restoring, one quotient bit per cycle; quotient sign = sign(a) xor sign(b); remainder sign = sign(a).
REQ-018 COMPUTE: counter decrements each cycle; at counter = 1, final value written to result, go to DONE.
REQ-019 Divide by zero (b = 0, DIV/DIVU/REM/REMU): skip COMPUTE, go directly IDLE -> DONE; quotient = all ones, remainder = operand_a.
REQ-020 Signed overflow (DIV/REM, a = most-negative, b = -1): skip COMPUTE; quotient = a, remainder = 0.
REQ-021 DONE: done = 1 for exactly one cycle, then IDLE.
REQ-022 Latency: start accepted in cycle N -> done in cycle N+XLEN+1; special cases (REQ-019/020) -> done in cycle N+1.
REQ-023 stall SHALL be high combinationally in the accepting cycle (IDLE & start & !flush) and throughout COMPUTE; low in DONE and IDLE.
REQ-024 busy SHALL be high in COMPUTE and DONE only.
REQ-025 start in COMPUTE or DONE SHALL be ignored; no queuing.
REQ-026 flush in COMPUTE or DONE: next state IDLE, done suppressed (no pulse in that cycle or later), result unchanged.
REQ-027 flush and start together in IDLE: flush wins; no operation accepted, stall low.
REQ-028 Operand changes after acceptance SHALL NOT affect the in-flight operation.
REQ-029 Arithmetic SHALL use XLEN+1-bit internal subtract and 2*XLEN-bit accumulator; no truncation before final select.

Reset
REQ-030 On reset: state = IDLE, counter = 0, result = 0, done = 0, busy = 0, stall = 0, internal accumulators = 0.
REQ-031 Reset asserted mid-operation SHALL abort with no done pulse; first start after reset deasserts is accepted normally.

Verification (XLEN = 32)
REQ-032 MUL 7 x 0xFFFFFFFD, start at cycle 0 -> result 0xFFFFFFEB, done at cycle 33, stall high cycles 0..32.
REQ-033 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
REQ-034 DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100 / 7 -> 14, REMU -> 2.
REQ-035 DIVU 5 / 0 -> 0xFFFFFFFF; REM 5 / 0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0; each with done at cycle 1 after start.
REQ-036 flush at cycle 10 of a MUL -> busy low at cycle 11, no done pulse, result keeps prior value; start issued concurrently with flush in IDLE -> ignored.
REQ-037 reset asserted at cycle 15 of a DIV -> all outputs 0 immediately; a new MUL 3 x 4 after release -> result 12 at the expected latency.
